uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19_200, serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..9, data bits per frame, LSB first.
REQ-004 SHALL have parameter PARITY, default PAR_ODD, one of PAR_NONE/PAR_EVEN/PAR_ODD.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two, 2..16.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port Sin, input, 1, asynchronous serial line, idles 1.
REQ-010 SHALL have port ReceiveAck, input, 1, consumer acknowledge, four-phase.
REQ-011 SHALL have port ClearOvr, input, 1, synchronous clear of Overrun.
REQ-012 SHALL have port Receive, output, 1, head FIFO entry available.
REQ-013 SHALL have port Dout, output, DATA_BITS, head entry data.
REQ-014 SHALL have port parityErr, output, 1, head entry parity error (always 0 when PAR_NONE).
REQ-015 SHALL have port frameErr, output, 1, head entry had a 0 in any stop bit.
REQ-016 SHALL have port Overrun, output, 1, sticky: a completed frame was dropped on full FIFO.

Function
REQ-017 Sin SHALL pass a two-flop synchronizer; all sampling uses the synchronized value.
REQ-018 BIT_CYCLES = CLK_FREQUENCY/BAUD_RATE (integer divide), HALF = BIT_CYCLES/2; counter width = $clog2(BIT_CYCLES+1).
REQ-019 FSM states IDLE, START, DATA, PAR, STOP; IDLE->START on synchronized 1->0 transition.
REQ-020 START: at HALF cycles sample; 0 -> DATA with baud counter reset; 1 -> IDLE (false start, nothing written).
REQ-021 DATA: sample every BIT_CYCLES at bit centre, shift in LSB first, DATA_BITS samples, then PAR (or STOP if PAR_NONE).
REQ-022 PAR: one sample; parityErr = received parity mismatches even/odd rule over data bits plus parity bit (odd: total ones odd).
REQ-023 STOP: STOP_BITS samples; frameErr set if any is 0; after last stop sample FSM -> IDLE same cycle (no wait for full stop bit).
REQ-024 Completed frame {Dout, parityErr, frameErr} SHALL be written to FIFO on the cycle after the last stop sample, including errored frames.
REQ-025 Receive SHALL assert one cycle after a write into an empty FIFO, unless acknowledge state blocks it (REQ-027).
REQ-026 Pop SHALL occur on the cycle ReceiveAck is sampled 1 while Receive is 1; exactly one entry per ReceiveAck assertion.
REQ-027 After a pop, Receive SHALL stay 0 until ReceiveAck is sampled 0, then reassert next cycle if FIFO non-empty.
REQ-028 Dout/parityErr/frameErr SHALL be valid whenever Receive=1 and hold stable until pop; undefined-but-stable otherwise.
REQ-029 Write when FIFO full SHALL drop the new frame, keep contents, set Overrun; simultaneous pop and write on full SHALL both succeed, no Overrun.
REQ-030 ClearOvr=1 SHALL clear Overrun next cycle; a simultaneous overrun event wins (Overrun stays 1).
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH+1).

Reset
REQ-032 rst=0 SHALL immediately force FSM IDLE, counters 0, FIFO empty, synchronizer to 1, Receive 0, Dout 0, parityErr 0, frameErr 0, Overrun 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; after release, reception restarts only on a new falling edge.

Structure
REQ-034 Package uart_pkg SHALL hold parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD), rx_state_t enum, and bit-cycle helper function.
REQ-035 FIFO SHALL be sub-module rx_fifo (parametrised width, depth; push, pop, full, empty, head outputs).

Verification
REQ-036 Defaults, bytes 0xFF,0x00,0x0F,0xF0,0x37,0x73,0xAA,0x55 with odd parity, ack each -> Dout matches, parityErr=0, frameErr=0.
REQ-037 Send 0x37 with even-parity bit under PAR_ODD -> Dout=0x37, parityErr=1; stop bit driven 0 on 0x55 -> frameErr=1.
REQ-038 Send 5 bytes 0x11..0x55 without ack (depth 4) -> first 4 read in order, 0x55 dropped, Overrun=1; ClearOvr -> Overrun=0.
REQ-039 Sin low pulse of HALF-10 cycles -> no write, Receive stays 0; following valid 0xA5 received correctly.
REQ-040 DATA_BITS=7, PARITY=PAR_NONE, STOP_BITS=2, send 0x5A -> Dout=0x5A; zero second stop bit -> frameErr=1.
REQ-041 rst=0 during data bit 4 of a frame with 2 entries queued -> Receive=0 immediately, FIFO empty, next full frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver with receive FIFO.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_t;

    // Clock cycles per serial bit; integer divide, remainder is dropped.
    function automatic int bit_cycles(input int clk_frequency, input int baud_rate);
        return clk_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO holding completed receive frames.
// The head entry is presented combinationally and reads as zero when empty.
module rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push on full still lands.
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame storage write.
    // NOTE: storage is deliberately not reset; the empty mask on head keeps outputs defined after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronizes Sin, samples frames at bit centres, queues
// {data, parity error, frame error} in a FIFO and hands entries to a consumer
// over a four-phase Receive/ReceiveAck handshake.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int      CLK_FREQUENCY = 100_000_000,
    parameter int      BAUD_RATE     = 19_200,
    parameter int      DATA_BITS     = 8,
    parameter parity_t PARITY        = PAR_ODD,
    parameter int      STOP_BITS     = 1,
    parameter int      FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Sin,
    input  logic                 ReceiveAck,
    input  logic                 ClearOvr,
    output logic                 Receive,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 Overrun
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = $clog2(BIT_CYCLES + 1);
    localparam int NW         = $clog2(DATA_BITS + 1);
    localparam int FW         = DATA_BITS + 2;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

    logic                 sin_meta;
    logic                 sin_sync;
    logic                 sin_prev;
    rx_state_t            state;
    logic [CW-1:0]        baud_cnt;
    logic [NW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err;
    logic                 frm_err;
    logic                 frame_done;
    logic                 baud_tick;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FW-1:0]        fifo_head;
    logic                 rx_pop;
    logic                 ack_block;

    assign baud_tick = (baud_cnt == BIT_LAST);
    assign rx_pop    = Receive && ReceiveAck;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sin_meta <= 1'b1;
            sin_sync <= 1'b1;
            sin_prev <= 1'b1;
        end else begin
            sin_meta <= Sin;
            sin_sync <= sin_meta;
            sin_prev <= sin_sync;
        end
    end

    // Receive FSM: start qualification, bit-centre sampling, parity and stop checks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (sin_prev && !sin_sync) state <= START;
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (!sin_sync) begin
                            state   <= DATA;
                            par_err <= 1'b0;
                            frm_err <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        shift    <= {sin_sync, shift[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY == PAR_NONE) ? STOP : PAR;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        // Odd rule wants an odd total of ones, even rule an even total.
                        par_err  <= (^shift) ^ sin_sync ^ (PARITY == PAR_ODD);
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (!sin_sync) frm_err <= 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt    <= '0;
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (frame_done),
        .din   ({shift, par_err, frm_err}),
        .pop   (rx_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign Dout      = fifo_head[FW-1:2];
    assign parityErr = fifo_head[1];
    assign frameErr  = fifo_head[0];

    // Four-phase handshake: after a pop, hold Receive low until ReceiveAck is seen low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Receive   <= 1'b0;
            ack_block <= 1'b0;
        end else if (rx_pop) begin
            Receive   <= 1'b0;
            ack_block <= 1'b1;
        end else if (ack_block) begin
            Receive <= 1'b0;
            if (!ReceiveAck) ack_block <= 1'b0;
        end else begin
            Receive <= !fifo_empty;
        end
    end

    // Sticky overrun: a dropped frame beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Overrun <= 1'b0;
        end else if (frame_done && fifo_full && !rx_pop) begin
            Overrun <= 1'b1;
        end else if (ClearOvr) begin
            Overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: instance A uses default framing (8 data, odd, 1 stop),
// instance B uses 7 data bits, no parity, 2 stop bits. Expected entries come from
// a queue model built from the frame definition.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 25_000;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int HALF   = BIT / 2;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin_a, sin_b;
    logic       ack_a, ack_b;
    logic       clr_a, clr_b;
    logic       rcv_a, rcv_b;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       ovr_a, ovr_b;

    exp_t q_a[$];
    exp_t q_b[$];
    bit   m_ovr_a, m_ovr_b;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] pat [8] = '{8'hFF, 8'h00, 8'h0F, 8'hF0, 8'h37, 8'h73, 8'hAA, 8'h55};

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQUENCY (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .FIFO_DEPTH    (DEPTH)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .Sin        (sin_a),
        .ReceiveAck (ack_a),
        .ClearOvr   (clr_a),
        .Receive    (rcv_a),
        .Dout       (dout_a),
        .parityErr  (perr_a),
        .frameErr   (ferr_a),
        .Overrun    (ovr_a)
    );

    uart_rx_fifo #(
        .CLK_FREQUENCY (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .DATA_BITS     (7),
        .PARITY        (PAR_NONE),
        .STOP_BITS     (2),
        .FIFO_DEPTH    (DEPTH)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .Sin        (sin_b),
        .ReceiveAck (ack_b),
        .ClearOvr   (clr_b),
        .Receive    (rcv_b),
        .Dout       (dout_b),
        .parityErr  (perr_b),
        .frameErr   (ferr_b),
        .Overrun    (ovr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Hold one line level for a full bit time.
    task automatic drive(input bit sel, input logic v);
        if (sel) sin_b = v;
        else     sin_a = v;
        repeat (BIT) @(negedge clk);
    endtask

    // Send one frame and record what the receiver should queue.
    task automatic send_frame(input bit sel, input logic [8:0] data, input bit flip_par,
                              input logic [1:0] stop_val);
        int         nb;
        int         ns;
        logic [8:0] dm;
        logic       par;
        exp_t       e;
        nb = sel ? 7 : 8;
        ns = sel ? 2 : 1;
        dm = data & ((9'h1 << nb) - 9'h1);
        e.data = dm;
        e.perr = 1'b0;
        e.ferr = 1'b0;
        drive(sel, 1'b0);
        for (int i = 0; i < nb; i++) drive(sel, dm[i]);
        if (!sel) begin
            par = ($countones(dm) % 2 == 0) ? 1'b1 : 1'b0;
            par = par ^ flip_par;
            drive(sel, par);
            e.perr = (($countones(dm) + int'(par)) % 2) != 1;
        end
        for (int i = 0; i < ns; i++) begin
            drive(sel, stop_val[i]);
            if (stop_val[i] == 1'b0) e.ferr = 1'b1;
        end
        drive(sel, 1'b1);
        if (sel) begin
            if (q_b.size() < DEPTH) q_b.push_back(e);
            else m_ovr_b = 1'b1;
        end else begin
            if (q_a.size() < DEPTH) q_a.push_back(e);
            else m_ovr_a = 1'b1;
        end
    endtask

    // Consume one entry through the four-phase handshake and compare it with the model.
    task automatic read_entry(input bit sel);
        exp_t e;
        int   n;
        if (sel) e = q_b.pop_front();
        else     e = q_a.pop_front();
        n = 0;
        while ((sel ? rcv_b : rcv_a) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("receive_up", 32'(sel ? rcv_b : rcv_a), 32'd1);
        if (sel) begin
            check("dout_b", 32'(dout_b), 32'(e.data));
            check("perr_b", 32'(perr_b), 32'(e.perr));
            check("ferr_b", 32'(ferr_b), 32'(e.ferr));
            ack_b = 1'b1;
        end else begin
            check("dout_a", 32'(dout_a), 32'(e.data));
            check("perr_a", 32'(perr_a), 32'(e.perr));
            check("ferr_a", 32'(ferr_a), 32'(e.ferr));
            ack_a = 1'b1;
        end
        @(negedge clk);
        check("receive_drop", 32'(sel ? rcv_b : rcv_a), 32'd0);
        repeat (3) @(negedge clk);
        check("receive_held", 32'(sel ? rcv_b : rcv_a), 32'd0);
        if (sel) ack_b = 1'b0;
        else     ack_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_ovr(input bit sel);
        if (sel) clr_b = 1'b1;
        else     clr_a = 1'b1;
        @(negedge clk);
        if (sel) begin
            clr_b   = 1'b0;
            m_ovr_b = 1'b0;
            check("overrun_clear_b", 32'(ovr_b), 32'(m_ovr_b));
        end else begin
            clr_a   = 1'b0;
            m_ovr_a = 1'b0;
            check("overrun_clear_a", 32'(ovr_a), 32'(m_ovr_a));
        end
    endtask

    initial begin
        bit         sel;
        int         n;
        logic [1:0] sv;
        logic [8:0] rd;

        rst   = 1'b0;
        sin_a = 1'b1;
        sin_b = 1'b1;
        ack_a = 1'b0;
        ack_b = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        m_ovr_a = 1'b0;
        m_ovr_b = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_receive_a", 32'(rcv_a), 32'd0);
        check("reset_dout_a",    32'(dout_a), 32'd0);
        check("reset_perr_a",    32'(perr_a), 32'd0);
        check("reset_ferr_a",    32'(ferr_a), 32'd0);
        check("reset_overrun_a", 32'(ovr_a), 32'd0);
        check("reset_receive_b", 32'(rcv_b), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Clean frames under default framing.
        for (int i = 0; i < 8; i++) begin
            send_frame(1'b0, {1'b0, pat[i]}, 1'b0, 2'b11);
            read_entry(1'b0);
        end

        // Wrong parity bit, then a zero stop bit.
        send_frame(1'b0, 9'h037, 1'b1, 2'b11);
        read_entry(1'b0);
        send_frame(1'b0, 9'h055, 1'b0, 2'b10);
        read_entry(1'b0);
        check("no_overrun", 32'(ovr_a), 32'(m_ovr_a));

        // Five frames into a four-deep FIFO without acknowledging.
        for (int i = 1; i <= 5; i++) send_frame(1'b0, 9'(i * 17), 1'b0, 2'b11);
        check("overrun_set", 32'(ovr_a), 32'(m_ovr_a));
        repeat (4) read_entry(1'b0);
        check("overrun_sticky", 32'(ovr_a), 32'(m_ovr_a));
        check("drained_receive", 32'(rcv_a), 32'(q_a.size() != 0));
        clear_ovr(1'b0);

        // Short low glitch must not start a frame.
        sin_a = 1'b0;
        repeat (HALF - 10) @(negedge clk);
        sin_a = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("glitch_ignored", 32'(rcv_a), 32'(q_a.size() != 0));
        send_frame(1'b0, 9'h0A5, 1'b0, 2'b11);
        read_entry(1'b0);

        // Seven data bits, no parity, two stop bits.
        send_frame(1'b1, 9'h05A, 1'b0, 2'b11);
        read_entry(1'b1);
        send_frame(1'b1, 9'h05A, 1'b0, 2'b01);
        read_entry(1'b1);

        // Reset in the middle of data bit 4 with two entries queued.
        send_frame(1'b0, 9'h03C, 1'b0, 2'b11);
        send_frame(1'b0, 9'h0C3, 1'b0, 2'b11);
        check("queued_receive", 32'(rcv_a), 32'(q_a.size() != 0));
        rd = 9'h096;
        drive(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, rd[i]);
        sin_a = rd[4];
        repeat (HALF) @(negedge clk);
        rst = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        m_ovr_a = 1'b0;
        m_ovr_b = 1'b0;
        check("midframe_reset_receive", 32'(rcv_a), 32'd0);
        check("midframe_reset_dout",    32'(dout_a), 32'd0);
        check("midframe_reset_overrun", 32'(ovr_a), 32'(m_ovr_a));
        sin_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("post_reset_empty", 32'(rcv_a), 32'(q_a.size() != 0));
        send_frame(1'b0, 9'h096, 1'b0, 2'b11);
        read_entry(1'b0);

        // Randomized bursts on either instance, occasionally with errors or overflow.
        for (int it = 0; it < 8; it++) begin
            sel = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                sv = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
                rd = 9'($urandom);
                send_frame(sel, rd, $urandom_range(0, 3) == 0, sv);
            end
            if (sel) check("rand_overrun_b", 32'(ovr_b), 32'(m_ovr_b));
            else     check("rand_overrun_a", 32'(ovr_a), 32'(m_ovr_a));
            while ((sel ? q_b.size() : q_a.size()) != 0) read_entry(sel);
            if (sel ? m_ovr_b : m_ovr_a) clear_ovr(sel);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
